// File: rtl/avmm_rr_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter: round-robin grant, one transaction
// at a time, read responses steered to the granted master, read-timeout watchdog.
module avmm_rr_arbiter #(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                RD_TIMEOUT = 255,
   parameter logic [DATA_W-1:0] TO_DATA    = '1
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,

   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,

   output logic [ADDR_W-1:0]     s_address,
   output logic                  s_read,
   output logic                  s_write,
   output logic [DATA_W-1:0]     s_writedata,
   output logic [DATA_W/8-1:0]   s_byteenable,
   input  logic                  s_waitrequest,
   input  logic [DATA_W-1:0]     s_readdata,
   input  logic                  s_readdatavalid,

   output logic                  err_timeout,
   output logic [1:0]            dbg_state
);

   localparam int BE_W   = DATA_W / 8;
   localparam int TCNT_W = $clog2(RD_TIMEOUT + 1);
   localparam logic [TCNT_W-1:0] TCNT_FIRE = TCNT_W'(RD_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CMD    = 2'd1,
      RDWAIT = 2'd2
   } state_t;

   state_t            state;
   logic              gnt;
   logic              last;
   logic [TCNT_W-1:0] tcnt;

   logic              req0, req1;
   logic              in_cmd;
   logic              g_read, g_write;
   logic [ADDR_W-1:0] g_address;
   logic [DATA_W-1:0] g_writedata;
   logic [BE_W-1:0]   g_byteenable;
   logic              rd_hit, to_fire, rsp_valid;
   logic [DATA_W-1:0] rsp_data;

   assign req0   = m0_read | m0_write;
   assign req1   = m1_read | m1_write;
   assign in_cmd = (state == CMD);

   always_comb begin
      g_read       = gnt ? m1_read       : m0_read;
      g_write      = gnt ? m1_write      : m0_write;
      g_address    = gnt ? m1_address    : m0_address;
      g_writedata  = gnt ? m1_writedata  : m0_writedata;
      g_byteenable = gnt ? m1_byteenable : m0_byteenable;
   end

   // tcnt == RD_TIMEOUT marks the cycle in which the synthetic timeout response
   // is delivered; a slave response arriving in that same cycle is dropped.
   assign to_fire   = (state == RDWAIT) && (tcnt == TCNT_FIRE);
   assign rd_hit    = (state == RDWAIT) && (tcnt != TCNT_FIRE) && s_readdatavalid;
   assign rsp_valid = rd_hit | to_fire;
   assign rsp_data  = to_fire ? TO_DATA : s_readdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         gnt         <= 1'b0;
         last        <= 1'b1;
         tcnt        <= '0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt   <= (req0 && req1) ? ~last : req1;
                  state <= CMD;
               end
            end
            CMD: begin
               if (!s_waitrequest) begin
                  if (g_read) begin
                     tcnt  <= '0;
                     state <= RDWAIT;
                  end else begin
                     last  <= gnt;
                     state <= IDLE;
                  end
               end
            end
            RDWAIT: begin
               if (to_fire) begin
                  err_timeout <= 1'b1;
                  last        <= gnt;
                  state       <= IDLE;
               end else if (s_readdatavalid) begin
                  last  <= gnt;
                  state <= IDLE;
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake: a master holds read/write and its qualifiers stable until it
   // samples waitrequest low; the command transfers on exactly that cycle, and
   // readdatavalid is a one-cycle strobe with readdata qualified by it.
   always_comb begin
      s_read       = in_cmd & g_read;
      s_write      = in_cmd & g_write & ~g_read;
      s_address    = in_cmd ? g_address    : '0;
      s_writedata  = in_cmd ? g_writedata  : '0;
      s_byteenable = in_cmd ? g_byteenable : '0;
   end

   always_comb begin
      m0_waitrequest   = !(in_cmd && !gnt && !s_waitrequest);
      m1_waitrequest   = !(in_cmd &&  gnt && !s_waitrequest);
      m0_readdatavalid = rsp_valid & ~gnt;
      m1_readdatavalid = rsp_valid &  gnt;
      m0_readdata      = (rsp_valid && !gnt) ? rsp_data : '0;
      m1_readdata      = (rsp_valid &&  gnt) ? rsp_data : '0;
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// Directed bench for avmm_rr_arbiter: per-cycle vector table plus hand-written
// timeout and reset-mid-read sequences.
module tb_avmm_rr_arbiter;

   localparam logic [31:0] M0_ADDR  = 32'h0000_0100;
   localparam logic [31:0] M0_WDATA = 32'hA5A5_A5A5;
   localparam logic [3:0]  M0_BE    = 4'hF;
   localparam logic [31:0] M1_ADDR  = 32'h0000_0040;
   localparam logic [31:0] M1_WDATA = 32'h5A5A_5A5A;
   localparam logic [3:0]  M1_BE    = 4'h3;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [31:0] s_address, s_writedata, s_readdata;
   logic [3:0]  s_byteenable;
   logic        s_read, s_write, s_waitrequest, s_readdatavalid;
   logic        err_timeout;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   avmm_rr_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_TIMEOUT(8), .TO_DATA(32'hFFFF_FFFF)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid),
      .err_timeout(err_timeout), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  in;      // {m0_rd, m0_wr, m1_rd, m1_wr, s_wait, s_rdv}
      logic [31:0] srd;
      logic [1:0]  scmd;    // {s_read, s_write}
      int          sel;     // 0: slave bus zero, 1: m0 fields, 2: m1 fields
      logic [3:0]  mflags;  // {m0_wait, m1_wait, m0_rdv, m1_rdv}
      logic [31:0] rd0;
      logic [31:0] rd1;
      logic [1:0]  st;
      logic        err;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [5:0] in, input logic [31:0] srd,
                               input logic [1:0] scmd, input int sel,
                               input logic [3:0] mflags, input logic [31:0] rd0,
                               input logic [31:0] rd1, input logic [1:0] st,
                               input logic err);
      vec_t v;
      v.in = in; v.srd = srd; v.scmd = scmd; v.sel = sel; v.mflags = mflags;
      v.rd0 = rd0; v.rd1 = rd1; v.st = st; v.err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a rising edge: drive, compare on the falling edge, advance.
   task automatic apply_vec(input vec_t v, input string tag);
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = v.in;
      s_readdata = v.srd;
      e_addr  = (v.sel == 1) ? M0_ADDR  : (v.sel == 2) ? M1_ADDR  : 32'h0;
      e_wdata = (v.sel == 1) ? M0_WDATA : (v.sel == 2) ? M1_WDATA : 32'h0;
      e_be    = (v.sel == 1) ? M0_BE    : (v.sel == 2) ? M1_BE    : 4'h0;
      @(negedge clk);
      chk({tag, ".s_read"},   32'(s_read),           32'(v.scmd[1]));
      chk({tag, ".s_write"},  32'(s_write),          32'(v.scmd[0]));
      chk({tag, ".s_addr"},   s_address,             e_addr);
      chk({tag, ".s_wdata"},  s_writedata,           e_wdata);
      chk({tag, ".s_be"},     32'(s_byteenable),     32'(e_be));
      chk({tag, ".m0_wait"},  32'(m0_waitrequest),   32'(v.mflags[3]));
      chk({tag, ".m1_wait"},  32'(m1_waitrequest),   32'(v.mflags[2]));
      chk({tag, ".m0_rdv"},   32'(m0_readdatavalid), 32'(v.mflags[1]));
      chk({tag, ".m1_rdv"},   32'(m1_readdatavalid), 32'(v.mflags[0]));
      chk({tag, ".m0_rdata"}, m0_readdata,           v.rd0);
      chk({tag, ".m1_rdata"}, m1_readdata,           v.rd1);
      chk({tag, ".state"},    32'(dbg_state),        32'(v.st));
      chk({tag, ".err"},      32'(err_timeout),      32'(v.err));
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      m0_address = M0_ADDR; m0_writedata = M0_WDATA; m0_byteenable = M0_BE;
      m1_address = M1_ADDR; m1_writedata = M1_WDATA; m1_byteenable = M1_BE;
      {m0_read, m0_write, m1_read, m1_write, s_waitrequest, s_readdatavalid} = 6'b0;
      s_readdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state.
      apply_vec(mk(6'b000000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0), "reset");

      // Contention from reset: m0 first, then strict alternation every 2 cycles.
      tbl.push_back(mk(6'b010100, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      tbl.push_back(mk(6'b010100, 32'h0, 2'b01, 1, 4'b0100, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b010100, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      tbl.push_back(mk(6'b010100, 32'h0, 2'b01, 2, 4'b1000, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b010100, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      tbl.push_back(mk(6'b010100, 32'h0, 2'b01, 1, 4'b0100, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b010100, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      tbl.push_back(mk(6'b010100, 32'h0, 2'b01, 2, 4'b1000, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b000000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      // Single master write.
      tbl.push_back(mk(6'b010000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      tbl.push_back(mk(6'b010000, 32'h0, 2'b01, 1, 4'b0100, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b000000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      // Read/write conflict: read wins, completes as a read; stray response ignored.
      tbl.push_back(mk(6'b110000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      tbl.push_back(mk(6'b110000, 32'h0, 2'b10, 1, 4'b0100, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b000001, 32'hCAFE_F00D, 2'b00, 0, 4'b1110, 32'hCAFE_F00D, 32'h0, 2'd2, 1'b0));
      tbl.push_back(mk(6'b000001, 32'hDEAD_BEEF, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      // m1 read with 3 wait states and latency 2 while m0 waits with a write.
      tbl.push_back(mk(6'b011010, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      tbl.push_back(mk(6'b011010, 32'h0, 2'b10, 2, 4'b1100, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b011010, 32'h0, 2'b10, 2, 4'b1100, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b011010, 32'h0, 2'b10, 2, 4'b1100, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b011000, 32'h0, 2'b10, 2, 4'b1000, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b010000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd2, 1'b0));
      tbl.push_back(mk(6'b010001, 32'h1234_5678, 2'b00, 0, 4'b1101, 32'h0, 32'h1234_5678, 2'd2, 1'b0));
      tbl.push_back(mk(6'b010000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));
      tbl.push_back(mk(6'b010000, 32'h0, 2'b01, 1, 4'b0100, 32'h0, 32'h0, 2'd1, 1'b0));
      tbl.push_back(mk(6'b000000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0));

      foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

      // Timeout: m0 read, slave silent; response exactly 8 cycles after RDWAIT entry.
      apply_vec(mk(6'b100000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0), "to_req");
      apply_vec(mk(6'b100000, 32'h0, 2'b10, 1, 4'b0100, 32'h0, 32'h0, 2'd1, 1'b0), "to_cmd");
      for (int k = 0; k <= 8; k++) begin
         if (k == 8)
            apply_vec(mk(6'b000000, 32'h0, 2'b00, 0, 4'b1110, 32'hFFFF_FFFF, 32'h0, 2'd2, 1'b0),
                      $sformatf("to_wait%0d", k));
         else
            apply_vec(mk(6'b000000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd2, 1'b0),
                      $sformatf("to_wait%0d", k));
      end
      apply_vec(mk(6'b000001, 32'h1111_1111, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b1), "to_late");

      // Reset for one cycle while m1 is in RDWAIT.
      apply_vec(mk(6'b001000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b1), "rst_req");
      apply_vec(mk(6'b001000, 32'h0, 2'b10, 2, 4'b1000, 32'h0, 32'h0, 2'd1, 1'b1), "rst_cmd");
      reset = 1'b1;
      apply_vec(mk(6'b000000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd2, 1'b1), "rst_rdwait");
      reset = 1'b0;
      apply_vec(mk(6'b000101, 32'h2222_2222, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0), "rst_after");
      apply_vec(mk(6'b000100, 32'h0, 2'b01, 2, 4'b1000, 32'h0, 32'h0, 2'd1, 1'b0), "rst_fresh");
      apply_vec(mk(6'b000000, 32'h0, 2'b00, 0, 4'b1100, 32'h0, 32'h0, 2'd0, 1'b0), "rst_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
